// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared helpers for the parametrised register file.
//   clog2        : address width from a register count
//   be_width     : number of byte lanes in a data word
//   merge_lane   : one byte lane of a dual-port write (port 2 has priority)
//   lane_visible : whether a byte lane survives the low-byte read extraction
// Ports: none (package).
package regfile_pkg;

    // Ceiling log2, evaluated at elaboration time for address widths.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) begin
                result = result + 1;
            end
        end
        return result;
    endfunction

    // One write-enable bit per byte of the data word.
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    // Merge one byte lane: keep the old byte unless a port enables the lane.
    // Port 2 is applied last so it wins when both ports enable the same lane.
    function automatic logic [7:0] merge_lane(
        input logic [7:0] old_byte,
        input logic [7:0] new_1,
        input logic       be_1,
        input logic [7:0] new_2,
        input logic       be_2
    );
        logic [7:0] result;
        result = old_byte;
        if (be_1) begin
            result = new_1;
        end
        if (be_2) begin
            result = new_2;
        end
        return result;
    endfunction

    // Low-byte reads keep lane 0 only; full reads keep every lane.
    function automatic logic lane_visible(input int lane, input logic low_byte);
        return !low_byte || (lane == 0);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Busy scoreboard for write-back hazard tracking.
//   clk, rst (async, active-low)
//   wr_any_1/2, wr_addr_1/2 : a port is writing at least one lane of wr_addr
//   rsv_en, rsv_addr        : reserve a register (mark busy until written)
//   busy                    : registered busy vector, one bit per register
//   rsv_err                 : one-cycle pulse after reserving an already-busy register
module regfile_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int AW       = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_any_1,
    input  logic [AW-1:0]       wr_addr_1,
    input  logic                wr_any_2,
    input  logic [AW-1:0]       wr_addr_2,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic [NUM_REGS-1:0] busy,
    output logic                rsv_err
);

    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;

    // Decode this cycle's reservation and write-back clears per register.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            set_vec[r] = rsv_en && (rsv_addr == AW'(r));
            clr_vec[r] = (wr_any_1 && (wr_addr_1 == AW'(r))) ||
                         (wr_any_2 && (wr_addr_2 == AW'(r)));
        end
    end

    // Set is applied after clear so a new reservation beats a same-cycle
    // write-back. An error is flagged only when the target stays busy
    // from an earlier reservation, i.e. it was not freed this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy    <= '0;
            rsv_err <= 1'b0;
        end else begin
            busy    <= (busy & ~clr_vec) | set_vec;
            rsv_err <= rsv_en && busy[rsv_addr] && !clr_vec[rsv_addr];
        end
    end

endmodule

// File: rtl/regfile_param.sv
// regfile_param
// Parametrised two-write / two-read register file with per-byte write
// enables, low-byte read extraction, a link-register read port and a busy
// scoreboard.
//   clk, rst (async, active-low)
//   wr_en/wr_addr/wr_data/wr_be _1/_2 : write ports, port 2 wins per lane
//   rd_addr/rd_low_byte _1/_2         : read ports
//   rd_data/rd_busy _1/_2             : read data and busy of addressed register
//   rd_data_link                      : full contents of LINK_REG
//   rsv_en/rsv_addr, rsv_err, busy    : reservation scoreboard
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data (and write-back busy clears) to the read ports.
module regfile_param
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = 16,
    parameter  int NUM_REGS = 16,
    parameter  int LINK_REG = 15,
    localparam int AW       = clog2(NUM_REGS),
    localparam int BE_W     = be_width(DATA_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en_1,
    input  logic [AW-1:0]       wr_addr_1,
    input  logic [DATA_W-1:0]   wr_data_1,
    input  logic [BE_W-1:0]     wr_be_1,
    input  logic                wr_en_2,
    input  logic [AW-1:0]       wr_addr_2,
    input  logic [DATA_W-1:0]   wr_data_2,
    input  logic [BE_W-1:0]     wr_be_2,
    input  logic [AW-1:0]       rd_addr_1,
    input  logic                rd_low_byte_1,
    output logic [DATA_W-1:0]   rd_data_1,
    output logic                rd_busy_1,
    input  logic [AW-1:0]       rd_addr_2,
    input  logic                rd_low_byte_2,
    output logic [DATA_W-1:0]   rd_data_2,
    output logic                rd_busy_2,
    output logic [DATA_W-1:0]   rd_data_link,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_err,
    output logic [NUM_REGS-1:0] busy
);

    logic [DATA_W-1:0] regs      [NUM_REGS];
    logic [DATA_W-1:0] next_regs [NUM_REGS];
    logic [BE_W-1:0]   be_hit_1  [NUM_REGS];
    logic [BE_W-1:0]   be_hit_2  [NUM_REGS];
    logic [DATA_W-1:0] raw_1;
    logic [DATA_W-1:0] raw_2;
    logic [DATA_W-1:0] raw_link;

    // Full-word lane merge built from the per-lane package helper.
    function automatic logic [DATA_W-1:0] merge_word(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_1,
        input logic [BE_W-1:0]   be_1,
        input logic [DATA_W-1:0] new_2,
        input logic [BE_W-1:0]   be_2
    );
        logic [DATA_W-1:0] result;
        result = old_word;
        for (int k = 0; k < BE_W; k++) begin
            result[8*k +: 8] = merge_lane(old_word[8*k +: 8], new_1[8*k +: 8], be_1[k],
                                          new_2[8*k +: 8], be_2[k]);
        end
        return result;
    endfunction

    // Zero every lane above lane 0 when a low-byte read is requested.
    function automatic logic [DATA_W-1:0] extract_word(
        input logic [DATA_W-1:0] data,
        input logic              low_byte
    );
        logic [DATA_W-1:0] result;
        result = '0;
        for (int k = 0; k < BE_W; k++) begin
            result[8*k +: 8] = lane_visible(k, low_byte) ? data[8*k +: 8] : 8'h00;
        end
        return result;
    endfunction

    // Per-register effective byte enables, and the value each register will
    // hold after the edge. A zero enable mask leaves the register unchanged,
    // so next_regs doubles as the bypass source.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            be_hit_1[r]  = (wr_en_1 && (wr_addr_1 == AW'(r))) ? wr_be_1 : '0;
            be_hit_2[r]  = (wr_en_2 && (wr_addr_2 == AW'(r))) ? wr_be_2 : '0;
            next_regs[r] = merge_word(regs[r], wr_data_1, be_hit_1[r], wr_data_2, be_hit_2[r]);
        end
    end

    // Storage array; reset clears it immediately and discards any write
    // presented during the reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '{default: '0};
        end else begin
            regs <= next_regs;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wr_any_1  (wr_en_1 && (wr_be_1 != '0)),
        .wr_addr_1 (wr_addr_1),
        .wr_any_2  (wr_en_2 && (wr_be_2 != '0)),
        .wr_addr_2 (wr_addr_2),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .busy      (busy),
        .rsv_err   (rsv_err)
    );

`ifdef REGFILE_BYPASS_EN
    // Read sources come from the post-write values, so a same-cycle write is
    // visible immediately with port 2 priority per lane.
    always_comb begin
        raw_1    = next_regs[rd_addr_1];
        raw_2    = next_regs[rd_addr_2];
        raw_link = next_regs[LINK_REG];
    end

    // A register being written back reads as free this cycle unless it is
    // simultaneously re-reserved.
    always_comb begin
        rd_busy_1 = busy[rd_addr_1] &&
                    (((be_hit_1[rd_addr_1] == '0) && (be_hit_2[rd_addr_1] == '0)) ||
                     (rsv_en && (rsv_addr == rd_addr_1)));
        rd_busy_2 = busy[rd_addr_2] &&
                    (((be_hit_1[rd_addr_2] == '0) && (be_hit_2[rd_addr_2] == '0)) ||
                     (rsv_en && (rsv_addr == rd_addr_2)));
    end
`else
    // Read sources are the stored array only.
    always_comb begin
        raw_1    = regs[rd_addr_1];
        raw_2    = regs[rd_addr_2];
        raw_link = regs[LINK_REG];
    end

    // Busy lookups straight from the registered scoreboard.
    always_comb begin
        rd_busy_1 = busy[rd_addr_1];
        rd_busy_2 = busy[rd_addr_2];
    end
`endif

    // Read outputs are forced to zero while reset is held so forwarded
    // write data cannot leak out during reset.
    always_comb begin
        rd_data_1    = rst ? extract_word(raw_1, rd_low_byte_1) : '0;
        rd_data_2    = rst ? extract_word(raw_2, rd_low_byte_2) : '0;
        rd_data_link = rst ? raw_link : '0;
    end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param
// Directed self-checking bench for regfile_param in its default
// configuration (16 x 16 bits, link register 15, no bypass).
module tb_regfile_param;

    logic        clk;
    logic        rst;
    logic        wr_en_1;
    logic [3:0]  wr_addr_1;
    logic [15:0] wr_data_1;
    logic [1:0]  wr_be_1;
    logic        wr_en_2;
    logic [3:0]  wr_addr_2;
    logic [15:0] wr_data_2;
    logic [1:0]  wr_be_2;
    logic [3:0]  rd_addr_1;
    logic        rd_low_byte_1;
    logic [15:0] rd_data_1;
    logic        rd_busy_1;
    logic [3:0]  rd_addr_2;
    logic        rd_low_byte_2;
    logic [15:0] rd_data_2;
    logic        rd_busy_2;
    logic [15:0] rd_data_link;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    logic        rsv_err;
    logic [15:0] busy;

    int checkCount = 0;
    int errorCount = 0;

    regfile_param #(
        .DATA_W   (16),
        .NUM_REGS (16),
        .LINK_REG (15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en_1       (wr_en_1),
        .wr_addr_1     (wr_addr_1),
        .wr_data_1     (wr_data_1),
        .wr_be_1       (wr_be_1),
        .wr_en_2       (wr_en_2),
        .wr_addr_2     (wr_addr_2),
        .wr_data_2     (wr_data_2),
        .wr_be_2       (wr_be_2),
        .rd_addr_1     (rd_addr_1),
        .rd_low_byte_1 (rd_low_byte_1),
        .rd_data_1     (rd_data_1),
        .rd_busy_1     (rd_busy_1),
        .rd_addr_2     (rd_addr_2),
        .rd_low_byte_2 (rd_low_byte_2),
        .rd_data_2     (rd_data_2),
        .rd_busy_2     (rd_busy_2),
        .rd_data_link  (rd_data_link),
        .rsv_en        (rsv_en),
        .rsv_addr      (rsv_addr),
        .rsv_err       (rsv_err),
        .busy          (busy)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Let one rising edge happen, then settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return every control input to its idle value.
    task automatic applyStimulus();
        wr_en_1 = 1'b0; wr_addr_1 = '0; wr_data_1 = '0; wr_be_1 = '0;
        wr_en_2 = 1'b0; wr_addr_2 = '0; wr_data_2 = '0; wr_be_2 = '0;
        rsv_en  = 1'b0; rsv_addr  = '0;
    endtask

    initial begin
        rst = 1'b0;
        rd_addr_1 = '0; rd_low_byte_1 = 1'b0;
        rd_addr_2 = '0; rd_low_byte_2 = 1'b0;
        applyStimulus();
        $display("[TB] reset phase");

        // Writes and reservations presented during reset must be discarded.
        wr_en_1 = 1'b1; wr_addr_1 = 4'd15; wr_data_1 = 16'h1234; wr_be_1 = 2'b11;
        rsv_en = 1'b1; rsv_addr = 4'd2;
        tick();
        tick();
        checkOutput("reset_link", 32'(rd_data_link), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_err", 32'(rsv_err), 32'h0);
        applyStimulus();
        #2;
        rst = 1'b1;
        tick();

        for (int a = 0; a < 16; a++) begin
            rd_addr_1 = 4'(a);
            #1;
            checkOutput($sformatf("post_reset_r%0d", a), 32'(rd_data_1), 32'h0);
        end
        checkOutput("post_reset_busy", 32'(busy), 32'h0);
        checkOutput("post_reset_err", 32'(rsv_err), 32'h0);

        // Full write to R13; not visible before the edge without bypass.
        $display("[TB] write phase");
        wr_en_1 = 1'b1; wr_addr_1 = 4'd13; wr_data_1 = 16'hFFFF; wr_be_1 = 2'b11;
        rd_addr_2 = 4'd13;
        #1;
        checkOutput("r13_before_edge", 32'(rd_data_2), 32'h0);
        tick();
        applyStimulus();
        checkOutput("r13_full", 32'(rd_data_2), 32'h0000FFFF);

        // Upper-lane-only write keeps the low byte.
        wr_en_1 = 1'b1; wr_addr_1 = 4'd13; wr_data_1 = 16'h1234; wr_be_1 = 2'b10;
        tick();
        applyStimulus();
        checkOutput("r13_upper_lane", 32'(rd_data_2), 32'h000012FF);

        // Enable with no lanes writes nothing.
        wr_en_2 = 1'b1; wr_addr_2 = 4'd13; wr_data_2 = 16'h0000; wr_be_2 = 2'b00;
        tick();
        applyStimulus();
        checkOutput("r13_zero_be", 32'(rd_data_2), 32'h000012FF);

        // Same-address dual write: lane 0 from port 2, lane 1 from port 1.
        wr_en_1 = 1'b1; wr_addr_1 = 4'd9; wr_data_1 = 16'hAAAA; wr_be_1 = 2'b11;
        wr_en_2 = 1'b1; wr_addr_2 = 4'd9; wr_data_2 = 16'h5555; wr_be_2 = 2'b01;
        tick();
        applyStimulus();
        rd_addr_1 = 4'd9;
        #1;
        checkOutput("r9_merge", 32'(rd_data_1), 32'h0000AA55);

        // Both ports on the same full lanes: port 2 wins.
        wr_en_1 = 1'b1; wr_addr_1 = 4'd7; wr_data_1 = 16'h1111; wr_be_1 = 2'b11;
        wr_en_2 = 1'b1; wr_addr_2 = 4'd7; wr_data_2 = 16'h2222; wr_be_2 = 2'b11;
        tick();
        applyStimulus();
        rd_addr_1 = 4'd7;
        #1;
        checkOutput("r7_port2_wins", 32'(rd_data_1), 32'h00002222);

        // Link register and low-byte extraction.
        wr_en_2 = 1'b1; wr_addr_2 = 4'd15; wr_data_2 = 16'hAFAF; wr_be_2 = 2'b11;
        tick();
        applyStimulus();
        rd_addr_1 = 4'd15; rd_low_byte_1 = 1'b1;
        rd_addr_2 = 4'd15; rd_low_byte_2 = 1'b0;
        #1;
        checkOutput("link_full", 32'(rd_data_link), 32'h0000AFAF);
        checkOutput("r15_low_byte", 32'(rd_data_1), 32'h000000AF);
        checkOutput("r15_full_read", 32'(rd_data_2), 32'h0000AFAF);
        rd_low_byte_1 = 1'b0;

        // Reservation, duplicate reservation error, zero-lane write, clear.
        $display("[TB] scoreboard phase");
        rsv_en = 1'b1; rsv_addr = 4'd4;
        rd_addr_1 = 4'd4;
        #1;
        checkOutput("busy_before_edge", 32'(rd_busy_1), 32'h0);
        tick();
        applyStimulus();
        checkOutput("busy_r4_set", 32'(busy), 32'h00000010);
        checkOutput("rd_busy_r4", 32'(rd_busy_1), 32'h1);
        checkOutput("no_err_first_rsv", 32'(rsv_err), 32'h0);

        rsv_en = 1'b1; rsv_addr = 4'd4;
        tick();
        applyStimulus();
        checkOutput("err_pulse", 32'(rsv_err), 32'h1);
        checkOutput("busy_r4_kept", 32'(busy), 32'h00000010);
        tick();
        checkOutput("err_one_cycle", 32'(rsv_err), 32'h0);

        wr_en_1 = 1'b1; wr_addr_1 = 4'd4; wr_data_1 = 16'h0077; wr_be_1 = 2'b00;
        tick();
        applyStimulus();
        checkOutput("zero_be_keeps_busy", 32'(busy), 32'h00000010);

        wr_en_1 = 1'b1; wr_addr_1 = 4'd4; wr_data_1 = 16'h0077; wr_be_1 = 2'b01;
        tick();
        applyStimulus();
        checkOutput("busy_r4_cleared", 32'(busy), 32'h0);
        checkOutput("r4_data", 32'(rd_data_1), 32'h00000077);

        // Reserve and write the same busy register: no error, stays busy.
        rsv_en = 1'b1; rsv_addr = 4'd5;
        tick();
        applyStimulus();
        rsv_en = 1'b1; rsv_addr = 4'd5;
        wr_en_2 = 1'b1; wr_addr_2 = 4'd5; wr_data_2 = 16'h0505; wr_be_2 = 2'b11;
        rd_addr_2 = 4'd5;
        tick();
        applyStimulus();
        checkOutput("rsv_wins_over_write", 32'(busy), 32'h00000020);
        checkOutput("no_err_when_freed", 32'(rsv_err), 32'h0);
        checkOutput("rd_busy2_r5", 32'(rd_busy_2), 32'h1);
        wr_en_2 = 1'b1; wr_addr_2 = 4'd5; wr_data_2 = 16'h0505; wr_be_2 = 2'b10;
        tick();
        applyStimulus();
        checkOutput("busy_r5_cleared", 32'(busy), 32'h0);

        // Mid-cycle reset with a pending reservation and error pulse.
        $display("[TB] mid-operation reset");
        rsv_en = 1'b1; rsv_addr = 4'd3;
        tick();
        rsv_en = 1'b1; rsv_addr = 4'd3;
        tick();
        applyStimulus();
        checkOutput("pre_reset_err", 32'(rsv_err), 32'h1);
        checkOutput("pre_reset_busy", 32'(busy), 32'h00000008);
        rd_addr_1 = 4'd13;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mid_reset_busy", 32'(busy), 32'h0);
        checkOutput("mid_reset_err", 32'(rsv_err), 32'h0);
        checkOutput("mid_reset_r13", 32'(rd_data_1), 32'h0);
        checkOutput("mid_reset_link", 32'(rd_data_link), 32'h0);
        tick();
        #2;
        rst = 1'b1;
        tick();
        checkOutput("after_reset_r13", 32'(rd_data_1), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-port CPU register file: next generation of the 16×16 two-write/two-read register file. Adds configurable width and depth, per-byte write enables (replacing the single first-byte-only mode), per-read-port low-byte extraction, a dedicated link-register read port at a configurable index, and a busy scoreboard for write-back hazard tracking. Sits between decode (reads, reservations) and write-back (writes) in the CPU datapath.

## Interface
- DATA_W, 16, register width in bits; multiple of 8
- NUM_REGS, 16, register count; power of two, ≥4
- LINK_REG, 15, index driven on rd_data_link
- (derived) AW = log2(NUM_REGS), BE_W = DATA_W/8

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- wr_en_1 / wr_en_2  in  1  write port enables
- wr_addr_1 / wr_addr_2  in  AW  write addresses
- wr_data_1 / wr_data_2  in  DATA_W  write data
- wr_be_1 / wr_be_2  in  BE_W  byte-lane enables; bit k covers bits [8k+7:8k]
- rd_addr_1 / rd_addr_2  in  AW  read addresses
- rd_low_byte_1 / rd_low_byte_2  in  1  return bits [7:0] zero-extended
- rd_data_1 / rd_data_2  out  DATA_W  read data
- rd_busy_1 / rd_busy_2  out  1  addressed register has a pending reservation
- rd_data_link  out  DATA_W  full contents of LINK_REG, never truncated
- rsv_en  in  1  reserve rsv_addr (mark busy until written)
- rsv_addr  in  AW  register to reserve
- rsv_err  out  1  registered pulse: reservation targeted an already-busy register
- busy  out  NUM_REGS  scoreboard vector

## Operation
- Reset (rst=0, async): all registers 0, busy all 0, rsv_err 0; every read output 0 while held.
- Write: on clk edge, for each port with wr_en=1, lanes with wr_be bit set update; other lanes hold. wr_en=1 with wr_be=0 writes nothing and does not clear busy.
- Same-address dual write: lane-by-lane merge; where both ports enable a lane, port 2 wins.
- Read: combinational from array. rd_low_byte=1 → {(DATA_W-8){0}, reg[7:0]}.
- Scoreboard: busy[r] set on edge with rsv_en & rsv_addr==r; cleared on edge with any port writing r with nonzero wr_be. Reserve and write to same r same cycle → busy stays 1 (new reservation wins).
- rsv_err: 1 for one cycle after an edge where rsv_en=1 and busy[rsv_addr] was already 1 (and not cleared that cycle); busy stays 1.
- rd_busy_n = busy[rd_addr_n], combinational from registered busy.

## Timing
- Write-to-read latency: 1 cycle without bypass (new value visible after edge).
- Reservation visible on busy/rd_busy 1 cycle after rsv_en edge.
- rsv_err asserted exactly one cycle, registered.
- rst asserted mid-operation: immediate clear; in-flight writes/reservations in that cycle discarded.

## Configuration
- REGFILE_BYPASS_EN defined: read ports and rd_data_link forward same-cycle write data lane-by-lane (port 2 priority) when address matches an enabled write; rd_busy reports 0 for a register being written with nonzero wr_be that cycle unless also reserved. Write-to-read latency 0.
- Undefined: reads reflect stored array only; no forwarding logic.

## Structure
- Package regfile_pkg: clog2 function, BE_W derivation, byte-lane merge function (old, new_1, be_1, new_2, be_2), read-extract function.
- Sub-module regfile_scoreboard: busy vector, reservation/clear logic, rsv_err register.
- Top holds storage array, write merge, read muxes, optional bypass.

## Test plan
- Reset then read all 16 addresses on rd_addr_1 → all 0, busy=0, rsv_err=0.
- Write FFFF to R13 via port 1, be=11 → rd_data_2 at R13 = FFFF next cycle (same cycle with REGFILE_BYPASS_EN).
- Both ports write R9 same cycle: port1 AAAA be=11, port2 5555 be=01 → R9 = AA55.
- Write AFAF to R15 via port 2 → rd_data_link = AFAF; rd_low_byte_1=1 with rd_addr_1=15 → rd_data_1 = 00AF.
- rsv_en R4 → busy[4]=1 next cycle; rsv_en R4 again → rsv_err pulse 1 cycle; write R4 be=01 → busy[4]=0.
- Reserve R3, assert rst=0 mid-cycle → busy, registers, rsv_err immediately 0.
